serial_acc_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one bit-serial accumulator datapath among NREQ requesters.
- Grants one requester at a time, muxes its N-bit operand to the datapath, and issues the load, carry-clear and N shift-enable cycles.
- Pulses a per-requester ack when the serial add completes.
- Services accumulator-clear requests between operations and keeps a sticky overflow flag from the datapath carry.

---
 rtl/serial_acc_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_serial_acc_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_acc_arbiter.sv
// Round-robin arbiter/sequencer sharing one bit-serial accumulator among NREQ requesters.
// Issues load, carry-clear and N shift cycles per add; services accumulator clears between adds.
//
// state  | meaning
// IDLE   | no owner; waiting for a clear request or an add request
// CLEAR  | one cycle of clear_acc; drops ovf and the pending clear
// LOAD   | granted operand loaded into the datapath, carry cleared
// SHIFT  | N shift-enable cycles; final carry folds into ovf
// FINISH | ack to the owner; pick the next clear or grant
module serial_acc_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   operand_flat,
    input  logic                acc_clr_req,
    input  logic                carry_in,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [N-1:0]        op_out,
    output logic                load_op,
    output logic                clr_carry,
    output logic                shift_en,
    output logic                clear_acc,
    output logic                busy,
    output logic                ovf
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_gnt_idx;
    logic            r_gnt_vld;
    logic [IW-1:0]   r_rr_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_clr_pending;
    logic            r_ovf;

    logic [NREQ-1:0] w_req_m;
    logic            w_found;
    logic [IW-1:0]   w_win_idx;
    logic            w_take_grant;
    logic            w_gnt_vld_nxt;
    logic            w_last_shift;

    assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == CW'(N - 1));

    // The finishing owner is masked so it cannot be re-granted back-to-back.
    always_comb begin
        w_req_m = req;
        if (r_state == S_FINISH) begin
            w_req_m[r_gnt_idx] = 1'b0;
        end
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = int'(r_rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && w_req_m[j]) begin
                w_found   = 1'b1;
                w_win_idx = IW'(j);
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_take_grant  = 1'b0;
        w_gnt_vld_nxt = r_gnt_vld;
        case (r_state)
            S_IDLE: begin
                if (r_clr_pending || acc_clr_req) begin
                    w_next_state = S_CLEAR;
                end else if (w_found) begin
                    w_next_state = S_LOAD;
                    w_take_grant = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_found) begin
                    w_next_state = S_LOAD;
                    w_take_grant = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last_shift) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                if (r_clr_pending) begin
                    w_next_state  = S_CLEAR;
                    w_gnt_vld_nxt = 1'b0;
                end else if (w_found) begin
                    w_next_state = S_LOAD;
                    w_take_grant = 1'b1;
                end else begin
                    w_next_state  = S_IDLE;
                    w_gnt_vld_nxt = 1'b0;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_gnt_vld_nxt = 1'b0;
            end
        endcase
        if (w_take_grant) begin
            w_gnt_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_gnt_idx     <= '0;
            r_gnt_vld     <= 1'b0;
            r_rr_ptr      <= IW'(NREQ - 1);
            r_cnt         <= '0;
            r_clr_pending <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_gnt_vld <= w_gnt_vld_nxt;
            if (w_take_grant) begin
                r_gnt_idx <= w_win_idx;
                r_rr_ptr  <= w_win_idx;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A pulse landing during CLEAR is covered by that clear.
            if (r_state == S_CLEAR) begin
                r_clr_pending <= 1'b0;
            end else if (acc_clr_req && (r_state != S_IDLE)) begin
                r_clr_pending <= 1'b1;
            end
            if (r_state == S_CLEAR) begin
                r_ovf <= 1'b0;
            end else if (w_last_shift && carry_in) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        gnt    = '0;
        op_out = '0;
        if (r_gnt_vld) begin
            gnt[r_gnt_idx] = 1'b1;
            op_out         = operand_flat[int'(r_gnt_idx)*N +: N];
        end
    end

    always_comb begin
        load_op   = (r_state == S_LOAD);
        clr_carry = (r_state == S_LOAD);
        shift_en  = (r_state == S_SHIFT);
        clear_acc = (r_state == S_CLEAR);
        busy      = (r_state != S_IDLE);
        ack       = (r_state == S_FINISH) ? gnt : '0;
        ovf       = r_ovf;
    end

endmodule

// File: tb/tb_serial_acc_arbiter.sv
// Self-checking bench for serial_acc_arbiter: expected acks queued at stimulus time,
// popped when the DUT acks; cycle-exact checks of the LOAD/SHIFT/FINISH/CLEAR timing.
module tb_serial_acc_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*N-1:0]   operand_flat;
    logic                acc_clr_req;
    logic                carry_in;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic [N-1:0]        op_out;
    logic                load_op;
    logic                clr_carry;
    logic                shift_en;
    logic                clear_acc;
    logic                busy;
    logic                ovf;

    serial_acc_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .operand_flat (operand_flat),
        .acc_clr_req  (acc_clr_req),
        .carry_in     (carry_in),
        .gnt          (gnt),
        .ack          (ack),
        .op_out       (op_out),
        .load_op      (load_op),
        .clr_carry    (clr_carry),
        .shift_en     (shift_en),
        .clear_acc    (clear_acc),
        .busy         (busy),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int              n_chk = 0;
    int              n_pass = 0;
    int              cyc = 0;
    int              last_ack_cyc = 0;
    logic            exp_ovf;
    logic [NREQ-1:0] sb_q[$];
    logic [NREQ-1:0] sb_exp;
    logic [NREQ-1:0] prev_g;
    logic [NREQ-1:0] cur_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Invariants every cycle, and the scoreboard pop on each ack.
    always @(negedge clk) begin
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        chk("ack_in_gnt", 32'(ack & ~gnt), 0);
        chk("ctl_excl", 32'($onehot0({load_op, shift_en, clear_acc})), 1);
        if (ack != '0) begin
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", 32'(ack), 0);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("ack_order", 32'(ack), 32'(sb_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    task automatic do_reset();
        reset       = 1'b1;
        req         = '0;
        acc_clr_req = 1'b0;
        carry_in    = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_load", 32'(load_op), 0);
        chk("rst_clrc", 32'(clr_carry), 0);
        chk("rst_shift", 32'(shift_en), 0);
        chk("rst_clracc", 32'(clear_acc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_op", 32'(op_out), 0);
        reset   = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // One complete add: req_set applied before the granting edge, req_after from LOAD on.
    task automatic add_one(input logic [NREQ-1:0] req_set, input logic [NREQ-1:0] req_after,
                           input logic [NREQ-1:0] exp_g, input logic [N-1:0] carry_pat,
                           input logic [N-1:0] clr_pat, input bit drop, input bit chk_period);
        int gi;
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (exp_g[i]) gi = i;
        req = req_set;
        sb_q.push_back(exp_g);
        step();
        chk("load_gnt", 32'(gnt), 32'(exp_g));
        chk("load_op", 32'(load_op), 1);
        chk("load_clrc", 32'(clr_carry), 1);
        chk("load_opout", 32'(op_out), 32'(operand_flat[gi*N +: N]));
        chk("load_busy", 32'(busy), 1);
        chk("load_ovf", 32'(ovf), 32'(exp_ovf));
        req = req_after;
        step();
        for (int k = 0; k < N; k++) begin
            chk("shift_en", 32'(shift_en), 1);
            chk("shift_gnt", 32'(gnt), 32'(exp_g));
            chk("shift_ack", 32'(ack), 0);
            carry_in    = carry_pat[k];
            acc_clr_req = clr_pat[k];
            step();
        end
        carry_in    = 1'b0;
        acc_clr_req = 1'b0;
        exp_ovf     = exp_ovf | carry_pat[N-1];
        chk("fin_ack", 32'(ack), 32'(exp_g));
        chk("fin_gnt", 32'(gnt), 32'(exp_g));
        chk("fin_shift", 32'(shift_en), 0);
        chk("fin_ovf", 32'(ovf), 32'(exp_ovf));
        if (chk_period) chk("rr_period", 32'(cyc - last_ack_cyc), 32'(N + 2));
        last_ack_cyc = cyc;
        if (drop) req = req & ~exp_g;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 32'({busy, gnt, ack, clear_acc}), 0);
    endtask

    initial begin
        reset        = 1'b1;
        req          = '0;
        acc_clr_req  = 1'b0;
        carry_in     = 1'b0;
        exp_ovf      = 1'b0;
        for (int i = 0; i < NREQ; i++) operand_flat[i*N +: N] = N'($urandom_range(1, 255));
        do_reset();

        // single add from requester 0
        add_one(4'b0001, 4'b0001, 4'b0001, 8'h00, 8'h00, 1'b1, 1'b0);
        step();
        chk_idle("t1_idle");

        // round-robin fairness with requesters re-raising one cycle after their ack
        do_reset();
        prev_g = '0;
        for (int i = 0; i < 6; i++) begin
            cur_g = NREQ'(1 << (i % NREQ));
            add_one(4'b1111 & ~prev_g, 4'b1111, cur_g, 8'h00, 8'h00, 1'b1, i > 0);
            prev_g = cur_g;
        end
        req = '0;
        step();
        chk_idle("t2_idle");

        // two clear pulses during requester 2's shift collapse into one CLEAR after its ack
        operand_flat[2*N +: N] = 8'hA5;
        add_one(4'b0110, 4'b0110, 4'b0100, 8'h80, 8'h05, 1'b1, 1'b0);
        operand_flat[2*N +: N] = 8'h3C;
        step();
        chk("t3_clear_acc", 32'(clear_acc), 1);
        chk("t3_clear_gnt", 32'(gnt), 0);
        chk("t3_clear_busy", 32'(busy), 1);
        chk("t3_clear_ovf", 32'(ovf), 1);
        exp_ovf = 1'b0;
        add_one(4'b0010, 4'b0010, 4'b0010, 8'h00, 8'h00, 1'b1, 1'b0);
        req = '0;
        step();
        chk_idle("t3_no_second_clear");

        // overflow only from the last shift cycle, sticky across adds
        add_one(4'b0001, 4'b0001, 4'b0001, 8'h7F, 8'h00, 1'b1, 1'b0);
        add_one(4'b0100, 4'b0100, 4'b0100, 8'h80, 8'h00, 1'b1, 1'b0);
        add_one(4'b1000, 4'b1000, 4'b1000, 8'h00, 8'h00, 1'b1, 1'b0);
        req = '0;
        step();
        chk_idle("t4_idle");
        chk("t4_ovf_sticky", 32'(ovf), 1);

        // requester 1 drops during its add; requester 0 holds through FINISH
        add_one(4'b0010, 4'b0000, 4'b0010, 8'h00, 8'h00, 1'b0, 1'b0);
        add_one(4'b0001, 4'b0001, 4'b0001, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        chk_idle("t5_mask_idle");
        add_one(4'b0001, 4'b0001, 4'b0001, 8'h00, 8'h00, 1'b1, 1'b0);

        // asynchronous reset mid-shift aborts without an ack and restarts round-robin
        req = 4'b0100;
        step();
        chk("t6_gnt", 32'(gnt), 32'(4'b0100));
        step();
        step();
        step();
        chk("t6_shift", 32'(shift_en), 1);
        chk("t6_ovf_pre", 32'(ovf), 32'(exp_ovf));
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(gnt), 0);
        chk("t6_async_shift", 32'(shift_en), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_ovf", 32'(ovf), 0);
        exp_ovf = 1'b0;
        req = '0;
        step();
        step();
        chk_idle("t6_in_reset");
        reset = 1'b0;
        add_one(4'b1010, 4'b1010, 4'b0010, 8'h00, 8'h00, 1'b1, 1'b0);
        add_one(4'b1000, 4'b1000, 4'b1000, 8'h00, 8'h00, 1'b1, 1'b0);
        req = '0;
        step();
        chk_idle("t6_idle");

        step();
        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
